// File: rtl/spi_tx_sched.sv
// spi_tx_sched: shares the SPI slave's single TX word between N_CH requesters.
// Each frame one pending requester is picked (round-robin or fixed priority),
// its payload is staged as {valid, ch_id, payload} and driven to the slave's TX
// buffer, and the requester is acked once the slave strobes data capture.
// The 2-bit RX word captured with each frame selects the next arbitration mode.
//
// Optional build macro: SPI_TX_SCHED_UNDERRUN_CNT_EN adds o_underrun_cnt, a
// saturating 8-bit underrun counter cleared by the reserved RX command 2'b11.
//
// state    | meaning
// S_EMPTY  | idle word on TX; stage a winner when mode allows and no strobe
// S_STAGED | staged word held on TX until the slave captures it
// S_ACK    | one-cycle ack to the granted channel, advance RR pointer
module spi_tx_sched #(
  parameter  int N_CH      = 4,
  parameter  int CH_BITS   = 2,
  parameter  int DATA_BITS = 13,
  localparam int TX_BITS   = 1 + CH_BITS + DATA_BITS
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [N_CH-1:0]           i_req_valid,
  input  logic [N_CH*DATA_BITS-1:0] i_req_data,
  output logic [N_CH-1:0]           o_req_ack,
  input  logic                      i_data_capt_st,
  input  logic [1:0]                i_RX_buff,
  output logic [TX_BITS-1:0]        o_TX_buff,
  output logic [1:0]                o_mode,
`ifdef SPI_TX_SCHED_UNDERRUN_CNT_EN
  output logic [7:0]                o_underrun_cnt,
`endif
  output logic                      o_underrun
);

  typedef enum logic [1:0] {S_EMPTY, S_STAGED, S_ACK} state_t;

  localparam logic [1:0] MODE_FIXED = 2'b01;
  localparam logic [1:0] MODE_HOLD  = 2'b10;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_capt_d1;
  logic                 w_capt_edge;
  logic [1:0]           r_mode;
  logic [CH_BITS-1:0]   r_ptr;
  logic [CH_BITS-1:0]   r_grant;
  logic [CH_BITS-1:0]   w_grant;
  logic                 w_any;
  logic [DATA_BITS-1:0] w_grant_data;
  logic [TX_BITS-1:0]   r_staged;
  logic                 r_underrun;
  logic                 w_stage;

  assign w_capt_edge = i_data_capt_st & ~r_capt_d1;
  assign o_mode      = r_mode;
  assign o_underrun  = r_underrun;

  // Strobe delay for edge detection; mode register reloads on every frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_capt_d1 <= 1'b0;
      r_mode    <= 2'b00;
    end else begin
      r_capt_d1 <= i_data_capt_st;
      if (w_capt_edge) r_mode <= i_RX_buff;
    end
  end

  // Winner selection. RR picks the valid channel at the smallest forward
  // distance from the pointer; only indices below N_CH are ever considered.
  always_comb begin
    int best_d;
    int d;
    w_any        = 1'b0;
    w_grant      = '0;
    w_grant_data = '0;
    best_d       = N_CH;
    d            = 0;
    for (int k = 0; k < N_CH; k++) begin
      if (r_mode == MODE_FIXED) begin
        d = k;
      end else if (k >= int'(r_ptr)) begin
        d = k - int'(r_ptr);
      end else begin
        d = k + N_CH - int'(r_ptr);
      end
      if (i_req_valid[k] && (d < best_d)) begin
        best_d  = d;
        w_any   = 1'b1;
        w_grant = CH_BITS'(k);
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      if (w_grant == CH_BITS'(k)) w_grant_data = i_req_data[k*DATA_BITS +: DATA_BITS];
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_EMPTY;
    else          r_state <= w_state_nxt;
  end

  // FSM next state and outputs; outputs decode registered state only.
  always_comb begin
    w_state_nxt = r_state;
    w_stage     = 1'b0;
    o_TX_buff   = '0;
    o_req_ack   = '0;
    case (r_state)
      S_EMPTY: begin
        if ((r_mode != MODE_HOLD) && w_any && !w_capt_edge) begin
          w_stage     = 1'b1;
          w_state_nxt = S_STAGED;
        end
      end
      S_STAGED: begin
        o_TX_buff = r_staged;
        if (w_capt_edge) w_state_nxt = S_ACK;
      end
      S_ACK: begin
        for (int k = 0; k < N_CH; k++) o_req_ack[k] = (r_grant == CH_BITS'(k));
        w_state_nxt = S_EMPTY;
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Staging register, RR pointer (wraps at N_CH) and underrun pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_grant    <= '0;
      r_staged   <= '0;
      r_ptr      <= '0;
      r_underrun <= 1'b0;
    end else begin
      if (w_stage) begin
        r_grant  <= w_grant;
        r_staged <= {1'b1, w_grant, w_grant_data};
      end
      if (r_state == S_ACK) begin
        r_ptr <= (r_grant == CH_BITS'(N_CH-1)) ? '0 : r_grant + CH_BITS'(1);
      end
      r_underrun <= w_capt_edge && (r_state == S_EMPTY);
    end
  end

`ifdef SPI_TX_SCHED_UNDERRUN_CNT_EN
  logic [7:0] r_underrun_cnt;

  assign o_underrun_cnt = r_underrun_cnt;

  // Saturating underrun counter; the reserved command clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_underrun_cnt <= 8'd0;
    end else if (w_capt_edge && (i_RX_buff == 2'b11)) begin
      r_underrun_cnt <= 8'd0;
    end else if (r_underrun && (r_underrun_cnt != 8'hFF)) begin
      r_underrun_cnt <= r_underrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_tx_sched.sv
// Bench for spi_tx_sched: scoreboard of expected acks/underruns, popped by a
// negedge monitor whenever the DUT pulses o_req_ack or o_underrun.
module tb_spi_tx_sched;

  localparam int N_CH      = 4;
  localparam int CH_BITS   = 2;
  localparam int DATA_BITS = 13;
  localparam int TX_BITS   = 1 + CH_BITS + DATA_BITS;

  logic                      i_clk = 1'b0;
  logic                      i_rst_n = 1'b0;
  logic [N_CH-1:0]           i_req_valid = '0;
  logic [N_CH*DATA_BITS-1:0] i_req_data;
  logic [N_CH-1:0]           o_req_ack;
  logic                      i_data_capt_st = 1'b0;
  logic [1:0]                i_RX_buff = 2'b00;
  logic [TX_BITS-1:0]        o_TX_buff;
  logic [1:0]                o_mode;
  logic                      o_underrun;
`ifdef SPI_TX_SCHED_UNDERRUN_CNT_EN
  logic [7:0]                o_underrun_cnt;
`endif

  logic [DATA_BITS-1:0] data_arr [N_CH];

  typedef struct {
    bit                   is_ack;
    int                   ch;
    logic [DATA_BITS-1:0] payload;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic [TX_BITS-1:0] last_word = '0;

  spi_tx_sched #(.N_CH(N_CH), .CH_BITS(CH_BITS), .DATA_BITS(DATA_BITS)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_req_valid    (i_req_valid),
    .i_req_data     (i_req_data),
    .o_req_ack      (o_req_ack),
    .i_data_capt_st (i_data_capt_st),
    .i_RX_buff      (i_RX_buff),
    .o_TX_buff      (o_TX_buff),
    .o_mode         (o_mode),
`ifdef SPI_TX_SCHED_UNDERRUN_CNT_EN
    .o_underrun_cnt (o_underrun_cnt),
`endif
    .o_underrun     (o_underrun)
  );

  always #5 i_clk = ~i_clk;

  always_comb begin
    i_req_data = '0;
    for (int k = 0; k < N_CH; k++) i_req_data[k*DATA_BITS +: DATA_BITS] = data_arr[k];
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_ack(input int ch, input logic [DATA_BITS-1:0] payload);
    sb_q.push_back('{1'b1, ch, payload});
  endtask

  task automatic exp_underrun();
    sb_q.push_back('{1'b0, 0, '0});
  endtask

  // One SPI frame: single-cycle capture strobe carrying the RX command.
  task automatic frame(input logic [1:0] rx);
    @(posedge i_clk); #1;
    i_RX_buff      = rx;
    i_data_capt_st = 1'b1;
    @(posedge i_clk); #1;
    i_data_capt_st = 1'b0;
    repeat (4) @(posedge i_clk);
    #1;
  endtask

  // Monitor: every ack/underrun pulse must match the head of the scoreboard.
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if ((o_req_ack != '0) || o_underrun) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected", {27'd0, o_req_ack, o_underrun}, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (e.is_ack) begin
            check_eq("ack_vec", 32'(o_req_ack), 32'(1 << e.ch));
            check_eq("ack_word", 32'(last_word), 32'({1'b1, CH_BITS'(e.ch), e.payload}));
            check_eq("ack_no_underrun", 32'(o_underrun), 32'd0);
          end else begin
            check_eq("underrun", 32'(o_underrun), 32'd1);
            check_eq("underrun_no_ack", 32'(o_req_ack), 32'd0);
          end
        end
      end
      if (o_TX_buff[TX_BITS-1]) last_word = o_TX_buff;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want summary before 500000");
    $fatal(1);
  end

  initial begin
    data_arr[0] = 13'h0123;
    data_arr[1] = 13'h0456;
    data_arr[2] = 13'h0789;
    data_arr[3] = 13'h1ABC;

    // 1: reset values, then underrun with nothing pending
    repeat (3) @(posedge i_clk);
    #1;
    check_eq("rst_tx", 32'(o_TX_buff), 32'd0);
    check_eq("rst_ack", 32'(o_req_ack), 32'd0);
    check_eq("rst_underrun", 32'(o_underrun), 32'd0);
    check_eq("rst_mode", 32'(o_mode), 32'd0);
    i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check_eq("idle_tx", 32'(o_TX_buff), 32'd0);
    exp_underrun();
    frame(2'b00);

    // 2: round-robin over all four channels
    i_req_valid = 4'b1111;
    for (int k = 0; k < N_CH; k++) begin
      exp_ack(k, data_arr[k]);
      frame(2'b00);
    end

    // 3: fixed priority with valids 1010; ch0 already staged still completes
    i_req_valid = 4'b1010;
    exp_ack(0, data_arr[0]);
    frame(2'b01);
    check_eq("mode_fixed", 32'(o_mode), 32'd1);
    for (int f = 0; f < 3; f++) begin
      exp_ack(1, data_arr[1]);
      frame(2'b01);
    end

    // 4: staged payload frozen, ack one cycle after the capture edge
    i_req_valid = 4'b1111;
    data_arr[2] = 13'h00AA;
    exp_ack(1, data_arr[1]);
    frame(2'b00);
    check_eq("stage_ch2", 32'(o_TX_buff), 32'({1'b1, 2'd2, 13'h00AA}));
    data_arr[2] = 13'h0155;
    repeat (2) @(posedge i_clk);
    #1;
    check_eq("frozen_payload", 32'(o_TX_buff[DATA_BITS-1:0]), 32'h00AA);
    exp_ack(2, 13'h00AA);
    @(posedge i_clk); #1;
    i_RX_buff      = 2'b00;
    i_data_capt_st = 1'b1;
    @(posedge i_clk); #1;
    i_data_capt_st = 1'b0;
    @(negedge i_clk);
    check_eq("ack_latency", 32'(o_req_ack), 32'b0100);
    repeat (3) @(posedge i_clk);
    #1;

    // 5: hold mode while ch3 staged, then resume RR at ch0
    exp_ack(3, data_arr[3]);
    frame(2'b10);
    check_eq("mode_hold", 32'(o_mode), 32'd2);
    check_eq("hold_tx", 32'(o_TX_buff), 32'd0);
    exp_underrun();
    frame(2'b10);
    exp_underrun();
    frame(2'b00);
    check_eq("resume_ch0", 32'(o_TX_buff), 32'({1'b1, 2'd0, data_arr[0]}));
    exp_ack(0, data_arr[0]);
    frame(2'b00);

    // 6: async reset while ch1 staged; re-staging restarts at ptr 0
    check_eq("pre_rst_ch1", 32'(o_TX_buff), 32'({1'b1, 2'd1, data_arr[1]}));
    @(posedge i_clk); #2;
    i_rst_n = 1'b0;
    #1;
    check_eq("async_rst_tx", 32'(o_TX_buff), 32'd0);
    check_eq("async_rst_ack", 32'(o_req_ack), 32'd0);
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    check_eq("restage_ch0", 32'(o_TX_buff), 32'({1'b1, 2'd0, data_arr[0]}));
    i_req_valid = 4'b0000;
    exp_ack(0, data_arr[0]);
    frame(2'b00);

`ifdef SPI_TX_SCHED_UNDERRUN_CNT_EN
    for (int f = 0; f < 300; f++) begin
      exp_underrun();
      frame(2'b00);
    end
    check_eq("cnt_sat", 32'(o_underrun_cnt), 32'd255);
    i_req_valid = 4'b0001;
    @(posedge i_clk); #1;
    i_req_valid = 4'b0000;
    exp_ack(0, data_arr[0]);
    frame(2'b11);
    check_eq("cnt_clear", 32'(o_underrun_cnt), 32'd0);
`endif

    repeat (3) @(posedge i_clk);
    #1;
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_tx_sched.md
Name: spi_tx_sched

Overview:
Shares the SPI slave's single TX word between N_CH requester channels.
- Each frame it picks one pending requester, using round-robin or fixed priority.
- It stages that requester's data and tags it with a valid flag and channel id, then drives the word into the SPI slave's TX buffer input.
- It acknowledges the requester once the slave reports the word captured (data-capture strobe).
- The 2-bit RX word from the slave selects the arbitration mode for the next frame.

Parameters:
N_CH, 4, number of requester channels (2..8)
CH_BITS, 2, channel id width; N_CH <= 2**CH_BITS
DATA_BITS, 13, payload bits per requester; TX word width TX_BITS = 1 + CH_BITS + DATA_BITS (16 at defaults)

Ports:
i_clk  in  1  system clock; all logic on rising edge
i_rst_n  in  1  reset, asynchronous, active-low
i_req_valid  in  N_CH  per-channel request; held high until matching ack
i_req_data  in  N_CH*DATA_BITS  channel k payload at bits [k*DATA_BITS +: DATA_BITS]
o_req_ack  out  N_CH  one-cycle pulse: channel's word was captured by the SPI slave
i_data_capt_st  in  1  capture strobe from the SPI slave
i_RX_buff  in  2  command word received from the SPI master
o_TX_buff  out  TX_BITS  word presented to the SPI slave: {valid, ch_id, payload}
o_mode  out  2  current arbitration mode register
o_underrun  out  1  one-cycle pulse: a frame was captured while nothing was staged

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - state EMPTY; o_TX_buff = 0 (idle word, valid flag 0).
  - o_req_ack = 0, o_underrun = 0, o_mode = 2'b00.
  - RR pointer = 0; capture-strobe delay register = 0.
- Capture edge: capt_edge = i_data_capt_st & ~capt_d1, where capt_d1 is i_data_capt_st registered. Same clock domain, so no synchroniser.
- Mode register:
  - Loads i_RX_buff on every capt_edge, in any state.
  - 00 = round-robin; 01 = fixed priority (lowest index wins).
  - 10 = hold: no new staging, idle word only.
  - 11 = reserved, behaves as 00.
- Arbitration (combinational, from registered pointer and i_req_valid):
  - RR: first valid channel searching ptr, ptr+1, ..., wrapping modulo N_CH.
  - Fixed: lowest valid index.
  - Channel ids >= N_CH never granted.
- FSM, 3 states:
  - EMPTY: o_TX_buff = 0.
    - If mode != 10 and any valid and no capt_edge this cycle: register grant index and stage {1, grant, i_req_data[grant]}, go to STAGED.
    - capt_edge in EMPTY: pulse o_underrun next cycle; stay EMPTY.
  - STAGED: o_TX_buff = staged word, held constant.
    - Payload changes on i_req_data are ignored after staging.
    - On capt_edge go to ACK.
  - ACK (one cycle): o_req_ack[grant] = 1; ptr <= (grant+1) mod N_CH; go to EMPTY.
- Latency: capt_edge at cycle c -> ack at c+1 -> earliest next staging at c+2.
- At most one ack bit is high in any cycle.
- Requester drops valid while staged: word is still sent and acked. This is a protocol violation and is not checked.
- Mode change to 10 while STAGED: the staged word is still completed and acked; no further staging afterwards.
- capt_edge while in ACK: cannot occur, since the strobe is at least 2 cycles apart. If it does, it is ignored except for the mode load.
- Reset asserted mid-operation: immediate return to reset values. The pending requester gets no ack and must keep its request asserted.
- Pointer arithmetic is done in CH_BITS width with explicit wrap at N_CH, not at 2**CH_BITS.

Optional Feature:
- Macro SPI_TX_SCHED_UNDERRUN_CNT_EN.
- When defined:
  - Adds output o_underrun_cnt, 8 bits, counting o_underrun pulses.
  - Saturates at 255; reset to 0.
  - Clears synchronously on a capt_edge whose i_RX_buff = 2'b11. The reserved-mode command doubles as clear, and that frame is still arbitrated as RR.
- When undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
1. Reset, then all valids low, mode 00.
   - Required: o_TX_buff = 0.
   - One capt_edge -> o_underrun pulses once; no ack.
2. Mode 00, valids = 4'b1111 held, 4 capt_edges.
   - Required: acks on channels 0, 1, 2, 3 in order.
   - o_TX_buff MSBs {1, ch} = 1_00, 1_01, 1_10, 1_11 with matching payloads.
3. RX = 01 loaded, valids = 4'b1010 held, 3 frames.
   - Required: every frame grants channel 1 (ack[1] each time); channel 3 never acked.
4. Channel 2 staged, payload then changed from 0x0AA to 0x155 before capt_edge.
   - Required: o_TX_buff payload stays 0x0AA; ack[2] exactly one cycle after capt_edge.
5. RX = 10 while STAGED.
   - Required: current word acked; next frames send 0 with o_underrun pulses.
   - Back to 00 -> RR resumes at grant+1.
6. i_rst_n pulsed low while STAGED.
   - Required: o_TX_buff = 0 and no ack, asynchronously.
   - Then re-staging from ptr 0.
   - With SPI_TX_SCHED_UNDERRUN_CNT_EN defined: 300 underruns -> count 255; RX = 11 frame -> count 0.
